branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

Sequencing stage that sits directly upstream of the branch history table and owns its single PC port. It accepts branch PCs from fetch, runs a read-only lookup to produce a taken/not-taken prediction, and records each prediction in an in-order queue. When execute resolves the oldest outstanding branch, it drives the table update, compares the outcome against the recorded prediction, and signals a mispredict with flush.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- PC_W, 16, PC width; must match the table's pc_bits width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- fetch_valid  in  1  fetch presents a branch PC for prediction
- fetch_pc  in  PC_W  branch PC
- fetch_ready  out  1  lookup accepted this cycle when high with fetch_valid
- pred_valid  out  1  one-cycle pulse: prediction for the last accepted fetch
- pred_taken  out  1  predicted direction
- resolve_valid  in  1  execute presents the outcome of the oldest branch
- resolve_taken  in  1  actual direction
- resolve_ready  out  1  queue non-empty; resolve accepted when high with resolve_valid
- mispredict  out  1  one-cycle pulse after a resolve whose outcome differs from its prediction
- queue_count  out  $clog2(DEPTH)+1  occupied entries
- bht_pc  out  PC_W  to table pc_bits
- bht_inc_dec  out  1  to table increment_decrement
- bht_read_only  out  1  to table read_only
- bht_count  in  2  from table count
- bht_tag_not_added  in  1  from table tag_not_added

## Operation
- Each cycle performs exactly one table access, chosen by priority: UPDATE > LOOKUP > IDLE.
- UPDATE (state RUN, resolve_valid & resolve_ready): bht_pc = head PC, bht_read_only = 0, bht_inc_dec = resolve_taken; head popped at clock edge; mispredict registered = resolve_taken != head prediction. fetch_ready = 0 this cycle.
- LOOKUP (state RUN, fetch_valid, queue not full, no update): bht_pc = fetch_pc, bht_read_only = 1; prediction = bht_count[1] & ~bht_tag_not_added (table miss predicts not-taken); {fetch_pc, prediction} pushed at tail; last_pc <= fetch_pc.
- IDLE: bht_pc = last_pc, bht_read_only = 1, bht_inc_dec = 0. Re-presenting last_pc keeps the table from allocating spurious entries.
- Update whose entry was evicted after lookup: table allocates fresh (counter 01) and does not count; no special handling here.
- Mispredict: queue cleared at the same edge as the pop (all younger entries are wrong-path). FSM RUN -> RECOVER; RECOVER lasts exactly one cycle (fetch_ready = 0, resolve_ready = 0, access IDLE) then -> RUN.
- fetch_ready = (state == RUN) & ~full & ~(resolve_valid & ~empty).
- Pointers wrap modulo DEPTH; full when queue_count == DEPTH.

## Timing
- Reset: state RUN, queue empty, queue_count 0, last_pc 0, pred_valid 0, pred_taken 0, mispredict 0; bht_read_only 1, bht_pc 0, bht_inc_dec 0. First idle cycle allocates tag 0 / set 0 in the table; accepted.
- bht_* outputs are combinational from state, queue head, and inputs; same-cycle table read.
- pred_valid/pred_taken registered: valid the cycle after the accepted fetch.
- mispredict registered: asserted the cycle after the resolve, coincident with RECOVER.
- Simultaneous fetch and resolve: resolve wins, fetch stalls one cycle.
- Reset mid-operation: queue discarded immediately; no pending pulses survive.

## Configuration
- BRQ_STATS_EN defined: adds outputs stat_lookups and stat_mispredicts (16 bits each, saturating at 16'hFFFF, reset 0), incremented on accepted lookup and on mispredict respectively.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package/header: PC_W, table index slice [8:2], tag slice [15:9], state encodings RUN/RECOVER.
- One sub-module: brq_fifo (circular buffer of {PC, prediction}, push/pop/clear, count, full/empty).

## Test plan
- Reset, fetch PC 0x0104 on a cold table -> table miss, pred_taken 0 next cycle, queue_count 1.
- Resolve taken three times for 0x0104 (lookup then update each time) -> fourth lookup pred_taken 1; no mispredict on the third or later resolves.
- Fill 4 lookups, hold fetch_valid -> fetch_ready 0 while full; one resolve -> fetch_ready 1 the following cycle.
- fetch_valid and resolve_valid asserted together -> bht_read_only 0 with bht_pc = head PC; fetch accepted next cycle.
- Queue of 3, oldest predicted not-taken, resolved taken -> mispredict pulse, queue_count 0, one RECOVER cycle with fetch_ready 0.
- Assert reset with queue of 2 mid-stream -> queue_count 0, all outputs at reset values, bht_read_only 1.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// branch_resolve_queue_pkg: shared constants, FSM states and prediction helper.
// Rev 1.0
`default_nettype none

package branch_resolve_queue_pkg;

    localparam int DEFAULT_PC_W = 16;
    localparam int IDX_HI = 8;
    localparam int IDX_LO = 2;
    localparam int TAG_HI = 15;
    localparam int TAG_LO = 9;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } brq_state_t;

    // A table miss predicts not-taken regardless of the counter it reports.
    function automatic logic predict(input logic [1:0] count, input logic tag_not_added);
        return count[1] & ~tag_not_added;
    endfunction

endpackage

`default_nettype wire

// File: rtl/brq_fifo.sv
// brq_fifo: circular buffer of {PC, prediction} with push/pop/clear and occupancy.
// Rev 1.0
`default_nettype none

module brq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[head];

    // Pointers are AW bits wide, so wrap modulo DEPTH happens naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: owns the BHT port, predicts fetched branches, resolves in order.
// Rev 1.0. Optional BRQ_STATS_EN adds saturating stat_lookups / stat_mispredicts.
`default_nettype none

module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = DEFAULT_PC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [PC_W-1:0]          fetch_pc,
    output logic                     fetch_ready,
    output logic                     pred_valid,
    output logic                     pred_taken,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [PC_W-1:0]          bht_pc,
    output logic                     bht_inc_dec,
    output logic                     bht_read_only,
    input  logic [1:0]               bht_count,
    input  logic                     bht_tag_not_added
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]              stat_lookups,
    output logic [15:0]              stat_mispredicts
`endif
);

    brq_state_t      state;
    brq_state_t      state_next;
    logic [PC_W-1:0] last_pc;
    logic [PC_W-1:0] head_pc;
    logic            head_pred;
    logic [PC_W:0]   head_entry;
    logic            full;
    logic            empty;
    logic            do_update;
    logic            do_lookup;
    logic            lookup_pred;
    logic            mispredict_next;

    assign lookup_pred = predict(bht_count, bht_tag_not_added);
    assign head_pc     = head_entry[PC_W:1];
    assign head_pred   = head_entry[0];

    // A mispredict clears the whole queue: everything younger is wrong-path.
    brq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (do_lookup),
        .push_data ({fetch_pc, lookup_pred}),
        .pop       (do_update),
        .clear     (mispredict_next),
        .head_data (head_entry),
        .count     (queue_count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // One table access per cycle: update beats lookup beats idle re-read of last_pc.
    always_comb begin
        state_next      = state;
        fetch_ready     = 1'b0;
        resolve_ready   = 1'b0;
        do_update       = 1'b0;
        do_lookup       = 1'b0;
        mispredict_next = 1'b0;
        bht_pc          = last_pc;
        bht_read_only   = 1'b1;
        bht_inc_dec     = 1'b0;
        case (state)
            RUN: begin
                resolve_ready = ~empty;
                do_update     = resolve_valid & ~empty;
                fetch_ready   = ~full & ~do_update;
                do_lookup     = fetch_valid & fetch_ready;
                if (do_update) begin
                    bht_pc          = head_pc;
                    bht_read_only   = 1'b0;
                    bht_inc_dec     = resolve_taken;
                    mispredict_next = resolve_taken ^ head_pred;
                    if (mispredict_next) state_next = RECOVER;
                end else if (do_lookup) begin
                    bht_pc = fetch_pc;
                end
            end
            RECOVER: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
            last_pc    <= '0;
        end else begin
            pred_valid <= do_lookup;
            pred_taken <= do_lookup & lookup_pred;
            mispredict <= mispredict_next;
            if (do_lookup) last_pc <= fetch_pc;
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (do_lookup && stat_lookups != 16'hFFFF)
                stat_lookups <= stat_lookups + 16'd1;
            if (mispredict_next && stat_mispredicts != 16'hFFFF)
                stat_mispredicts <= stat_mispredicts + 16'd1;
        end
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed stimulus, behavioural queue/table model, per-cycle compare.
// Rev 1.0
`default_nettype none

module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 16;
    localparam int TS    = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [15:0] fetch_pc = '0;
    logic        fetch_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        resolve_ready;
    logic        mispredict;
    logic [2:0]  queue_count;
    logic [15:0] bht_pc;
    logic        bht_inc_dec;
    logic        bht_read_only;
    logic [1:0]  bht_count;
    logic        bht_tag_not_added;

    int errors = 0;
    int checks = 0;

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_ready       (fetch_ready),
        .pred_valid        (pred_valid),
        .pred_taken        (pred_taken),
        .resolve_valid     (resolve_valid),
        .resolve_taken     (resolve_taken),
        .resolve_ready     (resolve_ready),
        .mispredict        (mispredict),
        .queue_count       (queue_count),
        .bht_pc            (bht_pc),
        .bht_inc_dec       (bht_inc_dec),
        .bht_read_only     (bht_read_only),
        .bht_count         (bht_count),
        .bht_tag_not_added (bht_tag_not_added)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch history table stand-in: fully associative, read-only miss allocates 00,
    // update miss allocates 01 without counting, update hit saturates.
    logic [15:0] t_pc  [TS] = '{default: '0};
    logic [1:0]  t_cnt [TS] = '{default: '0};
    logic        t_v   [TS] = '{default: 1'b0};

    always_comb begin
        bht_count         = 2'b00;
        bht_tag_not_added = 1'b1;
        for (int i = 0; i < TS; i++) begin
            if (t_v[i] && t_pc[i] == bht_pc) begin
                bht_count         = t_cnt[i];
                bht_tag_not_added = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        int h;
        int f;
        h = -1;
        f = -1;
        for (int i = 0; i < TS; i++) begin
            if (t_v[i] && t_pc[i] == bht_pc) h = i;
            if (!t_v[i] && f < 0) f = i;
        end
        if (h >= 0) begin
            if (!bht_read_only) begin
                if (bht_inc_dec) t_cnt[h] <= (t_cnt[h] == 2'd3) ? 2'd3 : t_cnt[h] + 2'd1;
                else             t_cnt[h] <= (t_cnt[h] == 2'd0) ? 2'd0 : t_cnt[h] - 2'd1;
            end
        end else if (f >= 0) begin
            t_v[f]   <= 1'b1;
            t_pc[f]  <= bht_pc;
            t_cnt[f] <= bht_read_only ? 2'd0 : 2'd1;
        end
    end

    function automatic logic tpred(input logic [15:0] pc);
        for (int i = 0; i < TS; i++)
            if (t_v[i] && t_pc[i] == pc) return t_cnt[i][1];
        return 1'b0;
    endfunction

    // Reference model: in-order queue of predictions plus recover flag.
    typedef struct packed {
        logic [15:0] pc;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    logic        m_rec  = 1'b0;
    logic [15:0] m_last = '0;
    logic        e_pv   = 1'b0;
    logic        e_pt   = 1'b0;
    logic        e_mis  = 1'b0;

    always @(negedge clk) begin
        logic emp;
        logic ful;
        logic upd;
        logic fr;
        logic lk;
        logic p;
        ent_t hd;
        if (reset) begin
            mq.delete();
            m_rec  = 1'b0;
            m_last = '0;
            e_pv   = 1'b0;
            e_pt   = 1'b0;
            e_mis  = 1'b0;
        end
        emp = (mq.size() == 0);
        ful = (mq.size() == DEPTH);
        hd  = emp ? '0 : mq[0];
        upd = !m_rec && resolve_valid && !emp;
        fr  = !m_rec && !ful && !(resolve_valid && !emp);
        lk  = fetch_valid && fr;

        chk("queue_count", 32'(queue_count), 32'(mq.size()));
        chk("fetch_ready", 32'(fetch_ready), 32'(fr));
        chk("resolve_ready", 32'(resolve_ready), 32'(!m_rec && !emp));
        chk("pred_valid", 32'(pred_valid), 32'(e_pv));
        if (e_pv) chk("pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        if (upd) begin
            chk("bht_pc_upd", 32'(bht_pc), 32'(hd.pc));
            chk("bht_ro_upd", 32'(bht_read_only), 32'd0);
            chk("bht_incdec_upd", 32'(bht_inc_dec), 32'(resolve_taken));
        end else if (lk) begin
            chk("bht_pc_lookup", 32'(bht_pc), 32'(fetch_pc));
            chk("bht_ro_lookup", 32'(bht_read_only), 32'd1);
        end else begin
            chk("bht_pc_idle", 32'(bht_pc), 32'(m_last));
            chk("bht_ro_idle", 32'(bht_read_only), 32'd1);
            chk("bht_incdec_idle", 32'(bht_inc_dec), 32'd0);
        end

        if (!reset) begin
            p     = tpred(fetch_pc);
            e_mis = upd && (resolve_taken != hd.pred);
            e_pv  = lk;
            e_pt  = lk && p;
            if (upd) void'(mq.pop_front());
            if (e_mis) mq.delete();
            if (lk) begin
                mq.push_back(ent_t'{pc: fetch_pc, pred: p});
                m_last = fetch_pc;
            end
            m_rec = e_mis;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [15:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        tick();
        fetch_valid = 1'b0;
        #1;
    endtask

    task automatic resolve(input logic taken);
        resolve_valid = 1'b1;
        resolve_taken = taken;
        tick();
        resolve_valid = 1'b0;
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_ro", 32'(bht_read_only), 32'd1);
        chk("rst_pc", 32'(bht_pc), 32'd0);
        chk("rst_pv", 32'(pred_valid), 32'd0);
        chk("rst_mis", 32'(mispredict), 32'd0);
        reset = 1'b0;
        tick();

        // Cold table: miss predicts not-taken.
        lookup(16'h0104);
        chk("cold_pv", 32'(pred_valid), 32'd1);
        chk("cold_pt", 32'(pred_taken), 32'd0);
        chk("cold_count", 32'(queue_count), 32'd1);

        // Train 0x0104 taken: counter 00 -> 01 -> 10 -> 11.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                lookup(16'h0104);
                chk("train_pt", 32'(pred_taken), 32'(i == 2));
            end
            resolve(1'b1);
            chk("train_mis", 32'(mispredict), 32'(i < 2));
            tick();
        end
        lookup(16'h0104);
        chk("trained_pt", 32'(pred_taken), 32'd1);
        resolve(1'b1);
        chk("trained_mis", 32'(mispredict), 32'd0);
        tick();

        // Fill to DEPTH, then hold fetch_valid while full.
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 16'h0200 + 16'(4 * i);
            tick();
        end
        fetch_pc = 16'h0210;
        #1;
        chk("full_fr", 32'(fetch_ready), 32'd0);
        chk("full_count", 32'(queue_count), 32'd4);
        tick();
        chk("full_fr2", 32'(fetch_ready), 32'd0);
        resolve(1'b0);
        chk("pop_fr", 32'(fetch_ready), 32'd1);
        chk("pop_count", 32'(queue_count), 32'd3);
        tick();
        chk("refill_count", 32'(queue_count), 32'd4);

        // Simultaneous fetch and resolve: update wins, fetch stalls a cycle.
        fetch_pc      = 16'h0300;
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        #1;
        chk("sim_ro", 32'(bht_read_only), 32'd0);
        chk("sim_pc", 32'(bht_pc), 32'h0204);
        chk("sim_fr", 32'(fetch_ready), 32'd0);
        tick();
        resolve_valid = 1'b0;
        #1;
        chk("sim_fr_next", 32'(fetch_ready), 32'd1);
        tick();
        fetch_valid = 1'b0;
        chk("sim_accept_pv", 32'(pred_valid), 32'd1);
        chk("sim_accept_count", 32'(queue_count), 32'd4);
        repeat (4) resolve(1'b0);
        chk("drain_count", 32'(queue_count), 32'd0);

        // Mispredict with three queued: queue flushed, one RECOVER cycle.
        lookup(16'h0400);
        lookup(16'h0404);
        lookup(16'h0408);
        fetch_valid   = 1'b1;
        fetch_pc      = 16'h040C;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        #1;
        chk("mis_pulse", 32'(mispredict), 32'd1);
        chk("mis_count", 32'(queue_count), 32'd0);
        chk("recover_fr", 32'(fetch_ready), 32'd0);
        chk("recover_rr", 32'(resolve_ready), 32'd0);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("post_recover_mis", 32'(mispredict), 32'd0);
        chk("post_recover_fr", 32'(fetch_ready), 32'd1);
        tick();

        // Asynchronous reset with two entries and a live pred_valid pulse.
        lookup(16'h0500);
        lookup(16'h0504);
        reset = 1'b1;
        #1;
        chk("midrst_count", 32'(queue_count), 32'd0);
        chk("midrst_pv", 32'(pred_valid), 32'd0);
        chk("midrst_pt", 32'(pred_taken), 32'd0);
        chk("midrst_mis", 32'(mispredict), 32'd0);
        chk("midrst_ro", 32'(bht_read_only), 32'd1);
        chk("midrst_pc", 32'(bht_pc), 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
